// File: rtl/verify_res1.sv
// Verification-result compressor: folds the challenge-side and view-side field buses
// into two 256-bit rotate-XOR digests (Ch, Cv) under a level start / done handshake.
module verify_res1 #(
    parameter int W = 256
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      round_idx,
    input  logic [255:0]    salt_a,
    input  logic [255:0]    salt_b,
    input  logic [511:0]    msg,
    input  logic [1023:0]   pub_key,
    input  logic [127:0]    chal,
    input  logic [9679:0]   z,
    input  logic [511:0]    com_a,
    input  logic [2047:0]   view_out,
    input  logic [1023:0]   com_b,
    input  logic [2047:0]   trans,
    input  logic [4095:0]   views,
    input  logic [51199:0]  tapes,
    input  logic [127:0]    iv,
    input  logic            sign_start,
    output logic [W-1:0]    Ch,
    output logic [W-1:0]    Cv,
    output logic            sign_end
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int CH_WORDS = 48;
    localparam int CV_WORDS = 239;
    localparam logic [7:0] LAST_CNT = 8'(CV_WORDS - 1);

    logic [CH_WORDS*W-1:0] ch_bus;
    logic [CV_WORDS*W-1:0] cv_bus;
    logic [W-1:0]          ch_words [CH_WORDS];
    logic [W-1:0]          cv_words [CV_WORDS];

    logic [1:0]   state_reg;
    logic [7:0]   cnt_reg;
    logic [W-1:0] acc_ch_reg;
    logic [W-1:0] acc_cv_reg;
    logic [W-1:0] ch_word;
    logic [W-1:0] cv_word;
    logic [W-1:0] ch_next;
    logic [W-1:0] cv_next;

    // Streams are laid out LSB word first; short fields are zero-extended to whole words.
    assign ch_bus = {48'b0, z, 128'b0, chal, pub_key, msg, salt_b, salt_a, 248'b0, round_idx};
    assign cv_bus = {128'b0, iv, tapes, views, trans, com_b, view_out, com_a};

    generate
        for (genvar gi = 0; gi < CH_WORDS; gi++) begin : g_ch_words
            assign ch_words[gi] = ch_bus[gi*W +: W];
        end
        for (genvar gi = 0; gi < CV_WORDS; gi++) begin : g_cv_words
            assign cv_words[gi] = cv_bus[gi*W +: W];
        end
    endgenerate

    // Past its last word the Ch stream keeps rotating with zero input so both streams see 239 steps.
    always_comb begin
        ch_word = '0;
        if (cnt_reg < 8'(CH_WORDS)) begin
            ch_word = ch_words[cnt_reg[5:0]];
        end
        cv_word = cv_words[cnt_reg];
    end

    assign ch_next = {acc_ch_reg[W-2:0], acc_ch_reg[W-1]} ^ ch_word;
    assign cv_next = {acc_cv_reg[W-2:0], acc_cv_reg[W-1]} ^ cv_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            acc_ch_reg <= '0;
            acc_cv_reg <= '0;
            Ch         <= '0;
            Cv         <= '0;
            sign_end   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    sign_end <= 1'b0;
                    if (sign_start) begin
                        acc_ch_reg <= '0;
                        acc_cv_reg <= '0;
                        cnt_reg    <= '0;
                        state_reg  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    acc_ch_reg <= ch_next;
                    acc_cv_reg <= cv_next;
                    if (cnt_reg == LAST_CNT) begin
                        Ch        <= ch_next;
                        Cv        <= cv_next;
                        sign_end  <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                ST_DONE: begin
                    if (!sign_start) begin
                        sign_end  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_verify_res1.sv
// Directed bench for verify_res1: handshake latency, single-bit digest positions,
// back-to-back independence, asynchronous abort and start dropped during a run.
module tb_verify_res1;

    logic            clk;
    logic            reset;
    logic [7:0]      round_idx;
    logic [255:0]    salt_a;
    logic [255:0]    salt_b;
    logic [511:0]    msg;
    logic [1023:0]   pub_key;
    logic [127:0]    chal;
    logic [9679:0]   z;
    logic [511:0]    com_a;
    logic [2047:0]   view_out;
    logic [1023:0]   com_b;
    logic [2047:0]   trans;
    logic [4095:0]   views;
    logic [51199:0]  tapes;
    logic [127:0]    iv;
    logic            sign_start;
    logic [255:0]    Ch;
    logic [255:0]    Cv;
    logic            sign_end;

    int checks = 0;
    int passes = 0;

    verify_res1 dut (
        .clk(clk), .reset(reset), .round_idx(round_idx), .salt_a(salt_a), .salt_b(salt_b),
        .msg(msg), .pub_key(pub_key), .chal(chal), .z(z), .com_a(com_a), .view_out(view_out),
        .com_b(com_b), .trans(trans), .views(views), .tapes(tapes), .iv(iv),
        .sign_start(sign_start), .Ch(Ch), .Cv(Cv), .sign_end(sign_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %b want %b", name, act, exp);
        else passes++;
    endtask

    task automatic chk_word(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h want %h", name, act, exp);
        else passes++;
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) $display("FAIL %s: got %0d want %0d", name, act, exp);
        else passes++;
    endtask

    // Reference: word k of each stream picked field by field, then the rotate-XOR fold.
    function automatic logic [255:0] ch_word_ref(input int k);
        logic [255:0] w;
        w = '0;
        if (k == 0) w = {248'b0, round_idx};
        else if (k == 1) w = salt_a;
        else if (k == 2) w = salt_b;
        else if (k < 5) w = msg[(k-3)*256 +: 256];
        else if (k < 9) w = pub_key[(k-5)*256 +: 256];
        else if (k == 9) w = {128'b0, chal};
        else if (k < 47) w = z[(k-10)*256 +: 256];
        else if (k == 47) w = {48'b0, z[9679:9472]};
        return w;
    endfunction

    function automatic logic [255:0] cv_word_ref(input int k);
        logic [255:0] w;
        w = '0;
        if (k < 2) w = com_a[k*256 +: 256];
        else if (k < 10) w = view_out[(k-2)*256 +: 256];
        else if (k < 14) w = com_b[(k-10)*256 +: 256];
        else if (k < 22) w = trans[(k-14)*256 +: 256];
        else if (k < 38) w = views[(k-22)*256 +: 256];
        else if (k < 238) w = tapes[(k-38)*256 +: 256];
        else w = {128'b0, iv};
        return w;
    endfunction

    function automatic logic [255:0] fold_ref(input bit use_cv);
        logic [255:0] acc;
        acc = '0;
        for (int k = 0; k < 239; k++) begin
            acc = {acc[254:0], acc[255]} ^ (use_cv ? cv_word_ref(k) : ch_word_ref(k));
        end
        return acc;
    endfunction

    task automatic clear_inputs();
        round_idx = '0; salt_a = '0; salt_b = '0; msg = '0; pub_key = '0; chal = '0; z = '0;
        com_a = '0; view_out = '0; com_b = '0; trans = '0; views = '0; tapes = '0; iv = '0;
    endtask

    task automatic set_all_ones();
        round_idx = '1; salt_a = '1; salt_b = '1; msg = '1; pub_key = '1; chal = '1; z = '1;
        com_a = '1; view_out = '1; com_b = '1; trans = '1; views = '1; tapes = '1; iv = '1;
    endtask

    // Called at posedge+1 in IDLE; returns edges counted after the start-sample edge.
    task automatic do_run(output int edges);
        sign_start = 1'b1;
        @(posedge clk); #1;
        edges = 0;
        while (!sign_end && edges < 400) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic finish_run();
        sign_start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [255:0] zero;
        zero = '0;
        reset = 1'b1;
        sign_start = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk_word("reset_ch", Ch, zero);
        chk_word("reset_cv", Cv, zero);
        chk_bit("reset_end", sign_end, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        int edges;
        logic [255:0] zero;
        zero = '0;
        clear_inputs();
        do_run(edges);
        chk_int("zero_latency", edges, 239);
        chk_word("zero_ch", Ch, zero);
        chk_word("zero_cv", Cv, zero);
        finish_run();
        chk_bit("zero_end_drop", sign_end, 1'b0);
        $display("run zero inputs: edges=%0d Ch=%h Cv=%h", edges, Ch, Cv);
    endtask

    task automatic test_single_bits();
        int edges;
        logic [255:0] exp_ch;
        logic [255:0] exp_cv;
        logic [255:0] zero;
        zero = '0;

        clear_inputs();
        round_idx = 8'h01;
        exp_ch = 256'd1 << 238;
        do_run(edges);
        chk_int("round_latency", edges, 239);
        chk_word("round_ch", Ch, exp_ch);
        chk_word("round_cv", Cv, zero);
        finish_run();
        $display("run round_idx=1: edges=%0d Ch=%h Cv=%h", edges, Ch, Cv);

        clear_inputs();
        iv = 128'h1;
        exp_cv = 256'd1;
        do_run(edges);
        chk_word("iv_cv", Cv, exp_cv);
        chk_word("iv_ch", Ch, zero);
        finish_run();
        $display("run iv=1: edges=%0d Ch=%h Cv=%h", edges, Ch, Cv);

        clear_inputs();
        tapes[0] = 1'b1;
        exp_cv = 256'd1 << 200;
        do_run(edges);
        chk_word("tapes_cv", Cv, exp_cv);
        chk_word("tapes_ch", Ch, zero);
        finish_run();
        $display("run tapes bit0: edges=%0d Ch=%h Cv=%h", edges, Ch, Cv);

        clear_inputs();
        salt_b = 256'h1;
        chal = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
        view_out[256] = 1'b1;
        exp_ch = (256'd1 << 236) ^ (256'd1 << (127 + 229));
        exp_ch = (256'd1 << 236) ^ (256'd1 << 100);
        exp_cv = 256'd1 << 235;
        do_run(edges);
        chk_word("mixed_ch", Ch, exp_ch);
        chk_word("mixed_cv", Cv, exp_cv);
        finish_run();
        $display("run salt_b/chal/view_out bits: edges=%0d Ch=%h Cv=%h", edges, Ch, Cv);
    endtask

    task automatic test_back_to_back();
        int edges;
        logic [255:0] exp_ch;
        logic [255:0] exp_cv;
        logic [255:0] first_ch;
        logic [255:0] first_cv;
        set_all_ones();
        exp_ch = fold_ref(1'b0);
        exp_cv = fold_ref(1'b1);
        do_run(edges);
        chk_int("ones1_latency", edges, 239);
        chk_word("ones1_ch", Ch, exp_ch);
        chk_word("ones1_cv", Cv, exp_cv);
        first_ch = Ch;
        first_cv = Cv;
        $display("run ones #1: edges=%0d Ch=%h Cv=%h", edges, Ch, Cv);
        repeat (3) @(posedge clk);
        #1;
        chk_bit("ones_done_hold", sign_end, 1'b1);
        finish_run();
        chk_bit("ones_end_drop", sign_end, 1'b0);
        repeat (74) @(posedge clk);
        #1;
        chk_word("ones_idle_hold_ch", Ch, first_ch);
        do_run(edges);
        chk_int("ones2_latency", edges, 239);
        chk_word("ones2_ch", Ch, first_ch);
        chk_word("ones2_cv", Cv, first_cv);
        finish_run();
        $display("run ones #2: edges=%0d Ch=%h Cv=%h", edges, Ch, Cv);
    endtask

    task automatic test_reset_mid();
        int edges;
        logic [255:0] zero;
        logic [255:0] exp_ch;
        zero = '0;
        exp_ch = 256'd1 << 238;
        clear_inputs();
        round_idx = 8'h01;
        sign_start = 1'b1;
        repeat (101) @(posedge clk);
        #3;
        reset = 1'b1;
        sign_start = 1'b0;
        #1;
        chk_word("abort_ch", Ch, zero);
        chk_word("abort_cv", Cv, zero);
        chk_bit("abort_end", sign_end, 1'b0);
        $display("abort at cnt~100: Ch=%h Cv=%h sign_end=%b", Ch, Cv, sign_end);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        do_run(edges);
        chk_int("after_abort_latency", edges, 239);
        chk_word("after_abort_ch", Ch, exp_ch);
        chk_word("after_abort_cv", Cv, zero);
        finish_run();
        $display("run after abort: edges=%0d Ch=%h Cv=%h", edges, Ch, Cv);
    endtask

    task automatic test_drop_start();
        int edges;
        logic [255:0] exp_ch;
        logic [255:0] exp_cv;
        clear_inputs();
        round_idx = 8'h01;
        iv = 128'h1;
        exp_ch = 256'd1 << 238;
        exp_cv = 256'd1;
        sign_start = 1'b1;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1;
        sign_start = 1'b0;
        edges = 10;
        while (!sign_end && edges < 400) begin
            @(posedge clk); #1;
            edges++;
        end
        chk_int("drop_latency", edges, 239);
        chk_word("drop_ch", Ch, exp_ch);
        chk_word("drop_cv", Cv, exp_cv);
        @(posedge clk); #1;
        chk_bit("drop_pulse_width", sign_end, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk_word("drop_hold_ch", Ch, exp_ch);
        chk_word("drop_hold_cv", Cv, exp_cv);
        $display("run start dropped: edges=%0d Ch=%h Cv=%h", edges, Ch, Cv);
    endtask

    initial begin
        test_reset();
        test_zero();
        test_single_bits();
        test_back_to_back();
        test_reset_mid();
        test_drop_start();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
